// File: rtl/hazard_controller_if.sv
// Pipeline-control bundle between the MIPS datapath and hazard_controller.
// Optional HAZARD_PERF_EN adds the stall/flush performance counters.
interface hazard_controller_if;
  typedef logic [4:0] regbits_t;

  logic     ihit;
  logic     dhit;
  regbits_t dec_rs;
  regbits_t dec_rt;
  logic     dec_useRs;
  logic     dec_useRt;
  logic     dec_isBranch;
  logic     dec_taken;
  logic     dec_halt;
  regbits_t ex_dest;
  regbits_t mem_dest;
  logic     ex_rfWEN;
  logic     mem_rfWEN;
  logic     ex_dREN;
  logic     mem_dREN;
  logic     mem_dWEN;
  logic     wb_halt;

  logic     pc_en;
  logic     ifde_en;
  logic     deex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifde_flush;
  logic     deex_flush;
  logic     halt;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output ihit, dhit, dec_rs, dec_rt, dec_useRs, dec_useRt, dec_isBranch,
           dec_taken, dec_halt, ex_dest, mem_dest, ex_rfWEN, mem_rfWEN,
           ex_dREN, mem_dREN, mem_dWEN, wb_halt,
    input  pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush,
           deex_flush, halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dec_rs, dec_rt, dec_useRs, dec_useRt, dec_isBranch,
           dec_taken, dec_halt, ex_dest, mem_dest, ex_rfWEN, mem_rfWEN,
           ex_dREN, mem_dREN, mem_dWEN, wb_halt,
    output pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush,
           deex_flush, halt, stall_cnt, flush_cnt
  );
`else
  modport master (
    output ihit, dhit, dec_rs, dec_rt, dec_useRs, dec_useRt, dec_isBranch,
           dec_taken, dec_halt, ex_dest, mem_dest, ex_rfWEN, mem_rfWEN,
           ex_dREN, mem_dREN, mem_dWEN, wb_halt,
    input  pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush,
           deex_flush, halt
  );

  modport slave (
    input  ihit, dhit, dec_rs, dec_rt, dec_useRs, dec_useRt, dec_isBranch,
           dec_taken, dec_halt, ex_dest, mem_dest, ex_rfWEN, mem_rfWEN,
           ex_dREN, mem_dREN, mem_dWEN, wb_halt,
    output pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush,
           deex_flush, halt
  );
`endif
endinterface

// File: rtl/hazard_controller.sv
// Five-stage MIPS hazard controller: load-use, branch-in-decode, cache-miss and halt drain.
// Define HAZARD_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module hazard_controller (
  input  logic               CLK,
  input  logic               nRST,
  hazard_controller_if.slave hif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t r_state;
  logic   r_halt;

  logic w_dwait;
  logic w_ex_match;
  logic w_mem_match;
  logic w_ldstall;
  logic w_redirect;
  logic w_pc_en;
  logic w_ifde_en;
  logic w_deex_en;
  logic w_exmem_en;
  logic w_memwb_en;
  logic w_ifde_flush;
  logic w_deex_flush;

  // Register 0 never carries a dependency, and an unused source never matches.
  assign w_ex_match  = (hif.ex_dest != 5'd0) && hif.ex_rfWEN &&
                       ((hif.dec_useRs && (hif.dec_rs == hif.ex_dest)) ||
                        (hif.dec_useRt && (hif.dec_rt == hif.ex_dest)));
  assign w_mem_match = (hif.mem_dest != 5'd0) && hif.mem_rfWEN &&
                       ((hif.dec_useRs && (hif.dec_rs == hif.mem_dest)) ||
                        (hif.dec_useRt && (hif.dec_rt == hif.mem_dest)));

  assign w_dwait   = (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;
  assign w_ldstall = (w_ex_match && hif.ex_dREN) ||
                     (hif.dec_isBranch && w_ex_match) ||
                     (hif.dec_isBranch && w_mem_match && hif.mem_dREN);

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    w_pc_en      = 1'b0;
    w_ifde_en    = 1'b0;
    w_deex_en    = 1'b0;
    w_exmem_en   = 1'b0;
    w_memwb_en   = 1'b0;
    w_ifde_flush = 1'b0;
    w_deex_flush = 1'b0;
    w_redirect   = 1'b0;

    if (!nRST) begin
      w_ifde_flush = 1'b1;
      w_deex_flush = 1'b1;
    end else if (r_state != HALTED) begin
      if (w_dwait) begin
        // everything frozen while the data cache is busy
      end else if (w_ldstall) begin
        w_deex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_deex_flush = 1'b1;
      end else if ((r_state == RUN) && !hif.ihit) begin
        w_ifde_en    = 1'b1;
        w_deex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_ifde_flush = 1'b1;
      end else if ((r_state == RUN) && hif.dec_taken) begin
        w_pc_en      = 1'b1;
        w_ifde_en    = 1'b1;
        w_deex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_ifde_flush = 1'b1;
        w_redirect   = 1'b1;
      end else begin
        w_pc_en      = 1'b1;
        w_ifde_en    = 1'b1;
        w_deex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
      end

      // Draining: fetch is closed and decode is fed bubbles until HALT retires.
      if (r_state == DRAIN) begin
        w_pc_en      = 1'b0;
        w_ifde_flush = 1'b1;
      end
    end
  end

  assign hif.pc_en      = w_pc_en;
  assign hif.ifde_en    = w_ifde_en;
  assign hif.deex_en    = w_deex_en;
  assign hif.exmem_en   = w_exmem_en;
  assign hif.memwb_en   = w_memwb_en;
  assign hif.ifde_flush = w_ifde_flush;
  assign hif.deex_flush = w_deex_flush;
  assign hif.halt       = r_halt;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
`ifdef HAZARD_PERF_EN
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          if (hif.dec_halt && !w_dwait && !w_ldstall)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (hif.wb_halt && !w_dwait) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
          end
        end
        default: begin
          // HALTED is sticky until reset
        end
      endcase
`ifdef HAZARD_PERF_EN
      if (r_state != HALTED) begin
        if (!w_pc_en)
          r_stall_cnt <= r_stall_cnt + 32'd1;
        if (w_redirect)
          r_flush_cnt <= r_flush_cnt + 32'd1;
      end
`endif
    end
  end

`ifdef HAZARD_PERF_EN
  assign hif.stall_cnt = r_stall_cnt;
  assign hif.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected control vectors are queued at drive
// time and compared at the following negedge, away from the active edge.
module tb_hazard_controller;

  logic CLK;
  logic nRST;

  hazard_controller_if hif ();

  hazard_controller dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hif  (hif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush, halt}
  localparam logic [7:0] V_RUN      = 8'b11111_00_0;
  localparam logic [7:0] V_LDSTALL  = 8'b00111_01_0;
  localparam logic [7:0] V_DWAIT    = 8'b00000_00_0;
  localparam logic [7:0] V_IMISS    = 8'b01111_10_0;
  localparam logic [7:0] V_REDIR    = 8'b11111_10_0;
  localparam logic [7:0] V_RESET    = 8'b00000_11_0;
  localparam logic [7:0] V_DRAIN    = 8'b01111_10_0;
  localparam logic [7:0] V_DRAIN_DW = 8'b00000_10_0;
  localparam logic [7:0] V_HALTED   = 8'b00000_00_1;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    logic [7:0] mask;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observed();
    return {hif.pc_en, hif.ifde_en, hif.deex_en, hif.exmem_en, hif.memwb_en,
            hif.ifde_flush, hif.deex_flush, hif.halt};
  endfunction

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check(e.tag, {24'd0, observed() & e.mask}, {24'd0, e.exp & e.mask});
    end
  end

  task automatic set_idle();
    hif.ihit = 1'b1;  hif.dhit = 1'b0;
    hif.dec_rs = 5'd0; hif.dec_rt = 5'd0;
    hif.dec_useRs = 1'b0; hif.dec_useRt = 1'b0;
    hif.dec_isBranch = 1'b0; hif.dec_taken = 1'b0; hif.dec_halt = 1'b0;
    hif.ex_dest = 5'd0; hif.mem_dest = 5'd0;
    hif.ex_rfWEN = 1'b0; hif.mem_rfWEN = 1'b0;
    hif.ex_dREN = 1'b0; hif.mem_dREN = 1'b0; hif.mem_dWEN = 1'b0;
    hif.wb_halt = 1'b0;
  endtask

  // Queue the expected vector for the current inputs, then advance one cycle.
  task automatic cycle(input string tag, input logic [7:0] exp, input logic [7:0] mask = 8'hFF);
    sb_t e;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic load_in_ex(input logic [4:0] dest);
    hif.ex_dest = dest; hif.ex_rfWEN = 1'b1; hif.ex_dREN = 1'b1;
  endtask

  task automatic load_in_mem(input logic [4:0] dest);
    hif.mem_dest = dest; hif.mem_rfWEN = 1'b1; hif.mem_dREN = 1'b1; hif.dhit = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    cycle("reset0", V_RESET);
    cycle("reset1", V_RESET);
    nRST = 1'b1;
    cycle("idle", V_RUN);

`ifdef HAZARD_PERF_EN
    check("stall_cnt_rst", hif.stall_cnt, 32'd0);
    check("flush_cnt_rst", hif.flush_cnt, 32'd0);
    hif.dec_taken = 1'b1;
    cycle("perf_redir0", V_REDIR);
    cycle("perf_redir1", V_REDIR);
    set_idle();
    check("flush_cnt_2", hif.flush_cnt, 32'd2);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    load_in_ex(5'd9); hif.dec_rs = 5'd9; hif.dec_useRs = 1'b1;
    cycle("perf_st0", V_LDSTALL);
    cycle("perf_st1", V_LDSTALL);
    cycle("perf_st2", V_LDSTALL);
    set_idle();
    check("stall_cnt_wrap", hif.stall_cnt, 32'h0000_0001);
`endif

    // Load-use on rs: one bubble, then the load has moved to MEM.
    load_in_ex(5'd5); hif.dec_rs = 5'd5; hif.dec_useRs = 1'b1;
    cycle("lduse_stall", V_LDSTALL);
    set_idle(); load_in_mem(5'd5); hif.dec_rs = 5'd5; hif.dec_useRs = 1'b1;
    cycle("lduse_go", V_RUN);

    // rt matches a load but the decode op does not read rt.
    set_idle(); load_in_ex(5'd7); hif.dec_rt = 5'd7;
    cycle("lduse_rt_unused", V_RUN);
    hif.dec_useRt = 1'b1;
    cycle("lduse_rt_used", V_LDSTALL);

    // BEQ behind LW r3: two stall cycles.
    set_idle(); load_in_ex(5'd3); hif.dec_isBranch = 1'b1; hif.dec_rs = 5'd3; hif.dec_useRs = 1'b1;
    cycle("brld_ex", V_LDSTALL);
    set_idle(); load_in_mem(5'd3); hif.dec_isBranch = 1'b1; hif.dec_rs = 5'd3; hif.dec_useRs = 1'b1;
    cycle("brld_mem", V_LDSTALL);
    set_idle(); hif.dec_isBranch = 1'b1; hif.dec_rs = 5'd3; hif.dec_useRs = 1'b1;
    cycle("brld_go", V_RUN);

    // BEQ behind ADDU r3: one stall cycle.
    hif.ex_dest = 5'd3; hif.ex_rfWEN = 1'b1;
    cycle("bralu_ex", V_LDSTALL);
    hif.ex_dest = 5'd0; hif.ex_rfWEN = 1'b0; hif.mem_dest = 5'd3; hif.mem_rfWEN = 1'b1;
    cycle("bralu_go", V_RUN);

    // Data miss with a concurrent instruction miss, then imiss once dhit arrives.
    set_idle(); hif.mem_dREN = 1'b1; hif.ihit = 1'b0;
    for (int i = 0; i < 4; i++) cycle($sformatf("dwait%0d", i), V_DWAIT);
    hif.dhit = 1'b1;
    cycle("dwait_done_imiss", V_IMISS);

    // Priority corners.
    set_idle(); hif.mem_dWEN = 1'b1; load_in_ex(5'd4); hif.dec_rs = 5'd4; hif.dec_useRs = 1'b1;
    cycle("dwait_over_ldstall", V_DWAIT);
    set_idle(); hif.ihit = 1'b0; hif.dec_taken = 1'b1;
    cycle("imiss_over_redir", V_IMISS);
    set_idle(); hif.dec_taken = 1'b1;
    cycle("redirect", V_REDIR);
    load_in_ex(5'd0); hif.dec_rs = 5'd0; hif.dec_useRs = 1'b1;
    cycle("redirect_r0", V_REDIR);

    // Reset in the middle of a stall; nothing pending afterwards.
    set_idle(); load_in_ex(5'd6); hif.dec_rs = 5'd6; hif.dec_useRs = 1'b1; nRST = 1'b0;
    cycle("reset_midstall", V_RESET);
    set_idle(); nRST = 1'b1;
    cycle("post_reset_run", V_RUN);

    // HALT blocked by a load-use stall does not start the drain.
    load_in_ex(5'd8); hif.dec_rs = 5'd8; hif.dec_useRs = 1'b1; hif.dec_halt = 1'b1;
    cycle("halt_blocked", V_LDSTALL);
    set_idle();
    cycle("halt_blocked_run", V_RUN);

    // Reset mid-drain returns to RUN.
    hif.dec_halt = 1'b1;
    cycle("halt_dec_a", V_RUN);
    set_idle();
    cycle("drain_a", V_DRAIN);
    nRST = 1'b0;
    cycle("reset_middrain", V_RESET);
    nRST = 1'b1;
    cycle("post_drain_reset", V_RUN);

    // Full halt sequence.
    hif.dec_halt = 1'b1;
    cycle("halt_dec", V_RUN);
    set_idle(); hif.ihit = 1'b0; hif.dec_taken = 1'b1;
    cycle("drain_ignore", V_DRAIN);
    set_idle();
    cycle("drain_1", V_DRAIN);
    hif.wb_halt = 1'b1; hif.mem_dWEN = 1'b1;
    cycle("drain_wbhalt_dwait", V_DRAIN_DW);
    hif.dhit = 1'b1;
    cycle("drain_wbhalt", V_DRAIN);
    for (int i = 0; i < 12; i++) begin
      hif.ihit = 1'($urandom_range(0, 1));
      hif.dhit = 1'($urandom_range(0, 1));
      hif.dec_taken = 1'($urandom_range(0, 1));
      hif.mem_dREN = 1'($urandom_range(0, 1));
      hif.wb_halt = 1'($urandom_range(0, 1));
      cycle($sformatf("halted%0d", i), V_HALTED);
    end
    set_idle(); nRST = 1'b0;
    cycle("reset_halted", V_RESET, 8'hFE);
    nRST = 1'b1;
    cycle("halt_cleared", V_RUN);

    @(negedge CLK);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
